// File: rtl/softex_pkg.sv
// Shared softex types: slot contents, controller/accumulator slot ops, and the
// slot manager's FSM state and response record.
package softex_pkg;

    localparam int unsigned SLOT_ADDR_BITS = 8;
    localparam int unsigned MAX_W          = 16;
    localparam int unsigned DEN_W          = 32;

    typedef struct packed {
        logic [MAX_W-1:0] maximum;
        logic [DEN_W-1:0] denominator;
        logic             valid;
    } slot_t;

    typedef enum logic {
        SLOT_ALLOC = 1'b0,
        SLOT_LOAD  = 1'b1
    } slot_req_op_e;

    typedef struct packed {
        slot_req_op_e              op;
        logic [SLOT_ADDR_BITS-1:0] addr;
    } slot_req_op_t;

    typedef enum logic {
        SLOT_UPDATE = 1'b0,
        SLOT_FREE   = 1'b1
    } slot_update_op_e;

    typedef struct packed {
        slot_update_op_e           op;
        logic [SLOT_ADDR_BITS-1:0] addr;
        logic [MAX_W-1:0]          maximum;
        logic [DEN_W-1:0]          denominator;
    } slot_update_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } slot_mgr_state_e;

    typedef struct packed {
        logic [SLOT_ADDR_BITS-1:0] addr;
        slot_t                     slot;
        logic                      error;
    } slot_rsp_t;

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter. MODE=0 counts trailing zeros (index of the
// lowest set bit), MODE=1 counts leading zeros. empty_o flags an all-zero input.
module lzc #(
    parameter int unsigned WIDTH     = 2,
    parameter bit          MODE      = 1'b0,
    parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    always_comb begin
        cnt_o   = '0;
        empty_o = 1'b1;
        if (!MODE) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (in_i[i]) begin
                    cnt_o   = CNT_WIDTH'(i);
                    empty_o = 1'b0;
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (in_i[i]) begin
                    cnt_o   = CNT_WIDTH'(WIDTH - 1 - i);
                    empty_o = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/softex_slot_lzc_alloc.sv
// First-free slot finder: lowest index with alloc=0, plus a full flag when no
// slot is free. Purely combinational.
module softex_slot_lzc_alloc
    import softex_pkg::*;
#(
    parameter int unsigned N_SLOTS   = 4,
    parameter int unsigned ADDR_BITS = softex_pkg::SLOT_ADDR_BITS
) (
    input  logic [N_SLOTS-1:0]   alloc_i,
    output logic [ADDR_BITS-1:0] idx_o,
    output logic                 full_o
);

    localparam int unsigned CNT_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

    logic [CNT_W-1:0] cnt;

    // Trailing-zero count over the free mask gives the lowest free index.
    lzc #(
        .WIDTH     (N_SLOTS),
        .MODE      (1'b0),
        .CNT_WIDTH (CNT_W)
    ) i_lzc (
        .in_i    (~alloc_i),
        .cnt_o   (cnt),
        .empty_o (full_o)
    );

    assign idx_o = ADDR_BITS'(cnt);

endmodule

// File: rtl/softex_slot_manager.sv
// Softmax slot manager: serialises ALLOC/LOAD requests with one outstanding
// response, applies UPDATE/FREE writebacks, and tracks slot occupancy.
module softex_slot_manager
    import softex_pkg::*;
#(
    parameter int unsigned N_SLOTS        = 4,
    parameter int unsigned SLOT_ADDR_BITS = softex_pkg::SLOT_ADDR_BITS
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  slot_req_op_t                 req_op_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [SLOT_ADDR_BITS-1:0]    rsp_addr_o,
    output slot_t                        rsp_slot_o,
    output logic                         rsp_error_o,
    input  logic                         update_valid_i,
    output logic                         update_ready_o,
    input  slot_update_op_t              update_op_i,
    output logic [$clog2(N_SLOTS+1)-1:0] n_alloc_o
);

    localparam int unsigned IDX_W  = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int unsigned CNT_W  = $clog2(N_SLOTS + 1);
    localparam int unsigned PKG_AW = softex_pkg::SLOT_ADDR_BITS;

    slot_mgr_state_e    state_q, state_d;
    logic [N_SLOTS-1:0] alloc_q, alloc_d;
    slot_t              entry_q [N_SLOTS];
    slot_t              entry_d [N_SLOTS];
    slot_rsp_t          rsp_q, rsp_d;
    logic [CNT_W-1:0]   n_alloc_q, n_alloc_d;

    logic [PKG_AW-1:0]  free_idx;
    logic               full;
    logic [IDX_W-1:0]   free_a, req_a, upd_a;
    logic               upd_hit, req_fire;

    function automatic logic in_range(input logic [PKG_AW-1:0] a);
        return 32'(a) < N_SLOTS;
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [N_SLOTS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    softex_slot_lzc_alloc #(
        .N_SLOTS   (N_SLOTS),
        .ADDR_BITS (PKG_AW)
    ) i_alloc (
        .alloc_i (alloc_q),
        .idx_o   (free_idx),
        .full_o  (full)
    );

    assign free_a   = IDX_W'(free_idx);
    assign req_a    = IDX_W'(req_op_i.addr);
    assign upd_a    = IDX_W'(update_op_i.addr);
    assign upd_hit  = update_valid_i && in_range(update_op_i.addr) && alloc_q[upd_a];
    assign req_fire = req_valid_i && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        alloc_d = alloc_q;
        entry_d = entry_q;
        rsp_d   = rsp_q;

        if (upd_hit) begin
            if (update_op_i.op == SLOT_UPDATE) begin
                entry_d[upd_a] = '{maximum:     update_op_i.maximum,
                                   denominator: update_op_i.denominator,
                                   valid:       1'b1};
            end else begin
                alloc_d[upd_a] = 1'b0;
                entry_d[upd_a] = '0;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (req_fire) begin
                    state_d = RESP;
                    rsp_d   = '0;
                    if (req_op_i.op == SLOT_ALLOC) begin
                        // Occupancy is sampled pre-edge, so a same-cycle FREE is invisible here.
                        if (full) begin
                            rsp_d.error = 1'b1;
                        end else begin
                            alloc_d[free_a] = 1'b1;
                            entry_d[free_a] = '0;
                            rsp_d.addr      = free_idx;
                        end
                    end else begin
                        rsp_d.addr = req_op_i.addr;
                        if (in_range(req_op_i.addr) && alloc_q[req_a]) begin
                            rsp_d.slot = entry_q[req_a];
                            // Write-first bypass for a same-cycle UPDATE; FREE keeps pre-free data.
                            if (upd_hit && (update_op_i.op == SLOT_UPDATE) && (upd_a == req_a)) begin
                                rsp_d.slot = '{maximum:     update_op_i.maximum,
                                               denominator: update_op_i.denominator,
                                               valid:       1'b1};
                            end
                        end else begin
                            rsp_d.error = 1'b1;
                        end
                    end
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clear_i) begin
            state_d = IDLE;
            alloc_d = '0;
            rsp_d   = '0;
            for (int unsigned i = 0; i < N_SLOTS; i++) begin
                entry_d[i] = '0;
            end
        end

        n_alloc_d = popcount(alloc_d);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            alloc_q   <= '0;
            entry_q   <= '{default: '0};
            rsp_q     <= '0;
            n_alloc_q <= '0;
        end else begin
            state_q   <= state_d;
            alloc_q   <= alloc_d;
            entry_q   <= entry_d;
            rsp_q     <= rsp_d;
            n_alloc_q <= n_alloc_d;
        end
    end

    assign req_ready_o    = (state_q == IDLE);
    assign rsp_valid_o    = (state_q == RESP);
    assign rsp_addr_o     = SLOT_ADDR_BITS'(rsp_q.addr);
    assign rsp_slot_o     = rsp_q.slot;
    assign rsp_error_o    = rsp_q.error;
    assign update_ready_o = 1'b1;
    assign n_alloc_o      = n_alloc_q;

endmodule

// File: tb/tb_softex_slot_manager.sv
// Directed bench for softex_slot_manager (N_SLOTS=4): allocation, load/update
// bypass, free, backpressure, clear and asynchronous reset.
module tb_softex_slot_manager;
    import softex_pkg::*;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            clear_i;
    logic            req_valid_i;
    logic            req_ready_o;
    slot_req_op_t    req_op_i;
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [7:0]      rsp_addr_o;
    slot_t           rsp_slot_o;
    logic            rsp_error_o;
    logic            update_valid_i;
    logic            update_ready_o;
    slot_update_op_t update_op_i;
    logic [2:0]      n_alloc_o;

    int checks = 0;
    int errors = 0;

    softex_slot_manager #(.N_SLOTS(4), .SLOT_ADDR_BITS(8)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clear_i        (clear_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_op_i       (req_op_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_addr_o     (rsp_addr_o),
        .rsp_slot_o     (rsp_slot_o),
        .rsp_error_o    (rsp_error_o),
        .update_valid_i (update_valid_i),
        .update_ready_o (update_ready_o),
        .update_op_i    (update_op_i),
        .n_alloc_o      (n_alloc_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // All stimulus tasks start and end on a falling edge.
    task automatic issue(input slot_req_op_e op, input logic [7:0] addr);
        req_valid_i   = 1'b1;
        req_op_i.op   = op;
        req_op_i.addr = addr;
        @(negedge clk_i);
        req_valid_i   = 1'b0;
    endtask

    task automatic consume();
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
    endtask

    task automatic upd(input slot_update_op_e op, input logic [7:0] addr,
                       input logic [15:0] mx, input logic [31:0] den);
        update_valid_i          = 1'b1;
        update_op_i.op          = op;
        update_op_i.addr        = addr;
        update_op_i.maximum     = mx;
        update_op_i.denominator = den;
        @(negedge clk_i);
        update_valid_i          = 1'b0;
    endtask

    task automatic check_rsp(input string tag, input logic [7:0] addr,
                             input logic [48:0] slot, input logic err);
        check({tag, "_valid"}, 64'(rsp_valid_o), 64'd1);
        check({tag, "_addr"},  64'(rsp_addr_o),  64'(addr));
        check({tag, "_slot"},  64'(rsp_slot_o),  64'(slot));
        check({tag, "_err"},   64'(rsp_error_o), 64'(err));
    endtask

    initial begin
        rst_ni         = 1'b0;
        clear_i        = 1'b0;
        req_valid_i    = 1'b0;
        req_op_i       = '0;
        rsp_ready_i    = 1'b0;
        update_valid_i = 1'b0;
        update_op_i    = '0;
        #12;
        check("rst_req_ready", 64'(req_ready_o), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("rst_rsp_addr",  64'(rsp_addr_o),  64'd0);
        check("rst_rsp_slot",  64'(rsp_slot_o),  64'd0);
        check("rst_rsp_err",   64'(rsp_error_o), 64'd0);
        check("rst_n_alloc",   64'(n_alloc_o),   64'd0);
        check("rst_upd_ready", 64'(update_ready_o), 64'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < 4; i++) begin
            issue(SLOT_ALLOC, 8'h00);
            check_rsp($sformatf("alloc%0d", i), 8'(i), 49'd0, 1'b0);
            check($sformatf("alloc%0d_n", i), 64'(n_alloc_o), 64'(i + 1));
            check($sformatf("alloc%0d_rdy", i), 64'(req_ready_o), 64'd0);
            consume();
        end
        issue(SLOT_ALLOC, 8'h00);
        check_rsp("alloc_full", 8'h00, 49'd0, 1'b1);
        check("alloc_full_n", 64'(n_alloc_o), 64'd4);
        consume();

        upd(SLOT_UPDATE, 8'd2, 16'h3F80, 32'h4000_0000);
        issue(SLOT_LOAD, 8'd2);
        check_rsp("load2", 8'd2, {16'h3F80, 32'h4000_0000, 1'b1}, 1'b0);
        consume();

        // LOAD and UPDATE of slot 1 in the same cycle.
        req_valid_i = 1'b1;
        req_op_i    = '{op: SLOT_LOAD, addr: 8'd1};
        upd(SLOT_UPDATE, 8'd1, 16'h1234, 32'hDEAD_BEEF);
        req_valid_i = 1'b0;
        check_rsp("bypass1", 8'd1, {16'h1234, 32'hDEAD_BEEF, 1'b1}, 1'b0);
        consume();

        issue(SLOT_LOAD, 8'd0);
        check_rsp("load0_fresh", 8'd0, 49'd0, 1'b0);
        consume();

        upd(SLOT_FREE, 8'd1, 16'h0, 32'h0);
        check("free1_n", 64'(n_alloc_o), 64'd3);
        issue(SLOT_ALLOC, 8'h00);
        check_rsp("realloc1", 8'd1, 49'd0, 1'b0);
        check("realloc1_n", 64'(n_alloc_o), 64'd4);
        consume();
        issue(SLOT_LOAD, 8'd1);
        check_rsp("load1_cleared", 8'd1, 49'd0, 1'b0);
        consume();
        issue(SLOT_LOAD, 8'd7);
        check("load7_err",  64'(rsp_error_o), 64'd1);
        check("load7_slot", 64'(rsp_slot_o),  64'd0);
        consume();

        upd(SLOT_FREE, 8'd3, 16'h0, 32'h0);
        upd(SLOT_UPDATE, 8'd3, 16'hAAAA, 32'h5555_5555);
        issue(SLOT_LOAD, 8'd3);
        check("load3_freed_err",  64'(rsp_error_o), 64'd1);
        check("load3_freed_slot", 64'(rsp_slot_o),  64'd0);
        consume();

        // LOAD and FREE of slot 2 together: pre-free contents, then freed.
        req_valid_i = 1'b1;
        req_op_i    = '{op: SLOT_LOAD, addr: 8'd2};
        upd(SLOT_FREE, 8'd2, 16'h0, 32'h0);
        req_valid_i = 1'b0;
        check_rsp("loadfree2", 8'd2, {16'h3F80, 32'h4000_0000, 1'b1}, 1'b0);
        check("loadfree2_n", 64'(n_alloc_o), 64'd2);
        consume();
        issue(SLOT_LOAD, 8'd2);
        check("load2_after_free", 64'(rsp_error_o), 64'd1);
        consume();

        // Backpressure: response holds and further requests are refused.
        issue(SLOT_LOAD, 8'd0);
        req_valid_i = 1'b1;
        req_op_i    = '{op: SLOT_ALLOC, addr: 8'd0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check_rsp($sformatf("hold%0d", i), 8'd0, 49'd0, 1'b0);
            check($sformatf("hold%0d_rdy", i), 64'(req_ready_o), 64'd0);
        end
        req_valid_i = 1'b0;
        check("hold_n", 64'(n_alloc_o), 64'd2);
        consume();
        check("release_valid", 64'(rsp_valid_o), 64'd0);
        check("release_rdy",   64'(req_ready_o), 64'd1);

        issue(SLOT_ALLOC, 8'h00);
        check_rsp("alloc2_again", 8'd2, 49'd0, 1'b0);
        consume();
        check("pre_clear_n", 64'(n_alloc_o), 64'd3);

        // Clear while in RESP, with competing update traffic.
        issue(SLOT_LOAD, 8'd0);
        clear_i = 1'b1;
        upd(SLOT_UPDATE, 8'd0, 16'h7777, 32'h7777_7777);
        clear_i = 1'b0;
        check("clear_valid", 64'(rsp_valid_o), 64'd0);
        check("clear_n",     64'(n_alloc_o),   64'd0);
        check("clear_rdy",   64'(req_ready_o), 64'd1);
        issue(SLOT_ALLOC, 8'h00);
        check_rsp("alloc_after_clear", 8'd0, 49'd0, 1'b0);
        consume();

        for (int i = 1; i < 4; i++) begin
            issue(SLOT_ALLOC, 8'h00);
            check($sformatf("refill%0d_addr", i), 64'(rsp_addr_o), 64'(i));
            consume();
        end
        // ALLOC with a same-cycle FREE of slot 0 still sees a full table.
        req_valid_i = 1'b1;
        req_op_i    = '{op: SLOT_ALLOC, addr: 8'd0};
        upd(SLOT_FREE, 8'd0, 16'h0, 32'h0);
        req_valid_i = 1'b0;
        check_rsp("alloc_vs_free", 8'd0, 49'd0, 1'b1);
        check("alloc_vs_free_n", 64'(n_alloc_o), 64'd3);
        consume();

        // Asynchronous reset in the middle of a pending response.
        issue(SLOT_LOAD, 8'd1);
        #2 rst_ni = 1'b0;
        #1;
        check("async_rst_valid", 64'(rsp_valid_o), 64'd0);
        check("async_rst_n",     64'(n_alloc_o),   64'd0);
        check("async_rst_rdy",   64'(req_ready_o), 64'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
